// File: rtl/seq_arith_unit.sv
// Registered add/subtract unit with valid/ready handshake, status flags and an optional
// multi-cycle shift-add unsigned multiplier.
module seq_arith_unit #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               cout,
  output logic               overflow,
  output logic               zero,
  output logic               negative,
  output logic               err,
  output logic               busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               out_valid_q, out_valid_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               err_q, err_d;

  logic               accept, is_mul, is_add;
  logic [WIDTH-1:0]   addb;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] partial, prod;

  assign in_ready = !rst && (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (op == 3'd4);
  assign is_add   = !op[2];

  always_comb begin
    case (op[1:0])
      2'd0:    addb = '0;
      2'd1:    addb = b;
      2'd2:    addb = ~b;
      default: addb = '1;
    endcase
    sum     = {1'b0, a} + {1'b0, addb} + (WIDTH + 1)'(cin);
    partial = b_q[count_q] ? ({{WIDTH{1'b0}}, a_q} << count_q) : '0;
    prod    = acc_q + partial;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    err_d       = err_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_mul) begin
            a_d     = a;
            b_d     = b;
            acc_d   = '0;
            count_d = '0;
            state_d = StMul;
          end else if (is_add) begin
            out_valid_d = 1'b1;
            result_d    = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
            cout_d      = sum[WIDTH];
            ovf_d       = (a[WIDTH-1] == addb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            zero_d      = (sum[WIDTH-1:0] == '0);
            neg_d       = sum[WIDTH-1];
            err_d       = 1'b0;
          end else begin
            out_valid_d = 1'b1;
            result_d    = '0;
            cout_d      = 1'b0;
            ovf_d       = 1'b0;
            zero_d      = 1'b1;
            neg_d       = 1'b0;
            err_d       = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d   = prod;
        count_d = count_q + 1'b1;
        // Last partial product is folded straight into the result register.
        if (count_q == LastCnt) begin
          state_d     = StIdle;
          out_valid_d = 1'b1;
          result_d    = prod;
          cout_d      = 1'b0;
          ovf_d       = |prod[2*WIDTH-1:WIDTH];
          zero_d      = (prod == '0);
          neg_d       = prod[2*WIDTH-1];
          err_d       = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign err       = err_q;
  assign busy      = (state_q == StMul);

endmodule

// File: tb/tb_seq_arith_unit.sv
// Scoreboard bench for seq_arith_unit: an 8-bit multiplier build plus a 16-bit add-only build.
module tb_seq_arith_unit;

  typedef struct packed {
    logic [15:0] res;
    logic        c, v, z, n, e;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, cin, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [2:0]  op;
  logic [15:0] result;
  logic        cout, overflow, zero, negative, err, busy;

  logic        in_valid_w, in_ready_w, cin_w, out_valid_w, out_ready_w;
  logic [15:0] a_w, b_w;
  logic [2:0]  op_w;
  logic [31:0] result_w;
  logic        cout_w, overflow_w, zero_w, negative_w, err_w, busy_w;

  seq_arith_unit #(.WIDTH(8), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .op(op), .out_valid(out_valid), .out_ready(out_ready), .result(result), .cout(cout),
    .overflow(overflow), .zero(zero), .negative(negative), .err(err), .busy(busy)
  );

  seq_arith_unit #(.WIDTH(16), .MUL_EN(1'b0)) u_dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w), .a(a_w), .b(b_w),
    .cin(cin_w), .op(op_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .result(result_w), .cout(cout_w), .overflow(overflow_w), .zero(zero_w),
    .negative(negative_w), .err(err_w), .busy(busy_w)
  );

  exp_t sb_q[$];
  int   pop_cyc_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(logic [15:0] r, logic c, logic v, logic z, logic n, logic e);
    exp_t x;
    x.res = r; x.c = c; x.v = v; x.z = z; x.n = n; x.e = e;
    return x;
  endfunction

  // Reference for 8-bit add ops 0-3.
  function automatic exp_t model8(logic [2:0] o, logic [7:0] x, logic [7:0] y, logic ci);
    logic [7:0] ab;
    logic [8:0] s;
    case (o)
      3'd0:    ab = 8'h00;
      3'd1:    ab = y;
      3'd2:    ab = ~y;
      default: ab = 8'hFF;
    endcase
    s = {1'b0, x} + {1'b0, ab} + {8'h00, ci};
    return mk({8'h00, s[7:0]}, s[8], (x[7] == ab[7]) && (s[7] != x[7]), s[7:0] == 8'h00,
              s[7], 1'b0);
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_out", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("result", {result, cout, overflow, zero, negative, err}, mon_e);
        pop_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic ci, input exp_t e);
    int  guard;
    logic acc;
    op = o; a = x; b = y; cin = ci; in_valid = 1'b1;
    sb_q.push_back(e);
    guard = 0;
    acc = 1'b0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      guard++;
    end
    #1 in_valid = 1'b0;
    if (!acc) check_eq("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_mul(input string tag);
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (!out_valid && n < 20) begin
      if (!(busy && !in_ready)) bad++;
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_latency"}, n, 8);
    check_eq({tag, "_busy"}, bad, 0);
    check_eq({tag, "_busy_done"}, {busy, out_valid}, 2'b01);
  endtask

  task automatic send_w(input string tag, input logic [2:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic ci, input logic [31:0] r,
                        input logic [5:0] f);
    op_w = o; a_w = x; b_w = y; cin_w = ci; in_valid_w = 1'b1;
    @(negedge clk);
    check_eq({tag, "_ready"}, in_ready_w, 1);
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    check_eq(tag, {out_valid_w, result_w, cout_w, overflow_w, zero_w, negative_w, err_w, busy_w},
             {1'b1, r, f});
  endtask

  logic [2:0] rop;
  logic [7:0] ra, rb;
  logic       rc;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = '0; out_ready = 1'b1;
    in_valid_w = 1'b0; a_w = '0; b_w = '0; cin_w = 1'b0; op_w = '0; out_ready_w = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_state", {in_ready, out_valid, result, cout, overflow, zero, negative, err,
             busy}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_ready", in_ready, 1);

    send(3'd1, 8'h7F, 8'h01, 1'b0, mk(16'h0080, 0, 1, 0, 1, 0));
    send(3'd2, 8'h05, 8'h05, 1'b1, mk(16'h0000, 1, 0, 1, 0, 0));
    send(3'd2, 8'h80, 8'h01, 1'b1, mk(16'h007F, 1, 1, 0, 0, 0));
    send(3'd3, 8'h00, 8'h00, 1'b0, mk(16'h00FF, 0, 0, 0, 1, 0));
    send(3'd0, 8'hFF, 8'h00, 1'b1, mk(16'h0000, 1, 0, 1, 0, 0));
    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rc  = 1'($urandom);
      send(rop, ra, rb, rc, model8(rop, ra, rb, rc));
    end
    repeat (2) @(posedge clk);
    #1;
    check_eq("drained", {sb_q.size(), out_valid}, {32'd0, 1'b0});

    send(3'd4, 8'hFF, 8'hFF, 1'b1, mk(16'hFE01, 0, 1, 0, 1, 0));
    wait_mul("mul_ff");
    send(3'd4, 8'h0F, 8'h03, 1'b0, mk(16'h002D, 0, 0, 0, 0, 0));
    wait_mul("mul_0f");
    repeat (2) @(posedge clk);
    #1;

    // Back-pressure: result must hold and input must stall.
    out_ready = 1'b0;
    send(3'd1, 8'h10, 8'h20, 1'b0, mk(16'h0030, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      check_eq("hold", {out_valid, in_ready, result, err}, {1'b1, 1'b0, 16'h0030, 1'b0});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    pop_cyc_q.delete();
    send(3'd1, 8'h01, 8'h02, 1'b0, mk(16'h0003, 0, 0, 0, 0, 0));
    send(3'd1, 8'hFF, 8'h01, 1'b0, mk(16'h0000, 1, 0, 1, 0, 0));
    send(3'd2, 8'h00, 8'h01, 1'b1, mk(16'h00FF, 0, 0, 0, 1, 0));
    send(3'd0, 8'h41, 8'h00, 1'b0, mk(16'h0041, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check_eq("burst_pops", pop_cyc_q.size(), 5);
    for (int i = 0; i + 1 < pop_cyc_q.size(); i++)
      check_eq("burst_consecutive", pop_cyc_q[i+1] - pop_cyc_q[i], 1);

    // Asynchronous reset in the middle of a multiply.
    send(3'd4, 8'h03, 8'h05, 1'b0, mk(16'h000F, 0, 0, 0, 0, 0));
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_mul", {in_ready, out_valid, result, cout, overflow, zero, negative, err,
             busy}, 0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_eq("no_stale", {out_valid, busy}, 2'b00);
      @(posedge clk); #1;
    end
    send(3'd6, 8'h12, 8'h34, 1'b1, mk(16'h0000, 0, 0, 1, 0, 1));
    send(3'd7, 8'hFF, 8'hFF, 1'b0, mk(16'h0000, 0, 0, 1, 0, 1));
    send(3'd1, 8'h01, 8'h01, 1'b0, mk(16'h0002, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check_eq("final_drain", sb_q.size(), 0);

    // WIDTH=16, MUL_EN=0; flag order {cout, ovf, zero, neg, err, busy}.
    send_w("w16_add_ovf", 3'd1, 16'h7FFF, 16'h0001, 1'b0, 32'h0000_8000, 6'b010100);
    send_w("w16_sub_zero", 3'd2, 16'h1234, 16'h1234, 1'b1, 32'h0000_0000, 6'b101000);
    send_w("w16_all1s", 3'd3, 16'h0000, 16'h0000, 1'b0, 32'h0000_FFFF, 6'b000100);
    send_w("w16_mul_illegal", 3'd4, 16'h0003, 16'h0005, 1'b0, 32'h0000_0000, 6'b001010);
    send_w("w16_op0_carry", 3'd0, 16'hFFFF, 16'h0000, 1'b1, 32'h0000_0000, 6'b101000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
